// File: rtl/alu_pkg.sv
// Shared opcodes, flag positions and FSM state type for the ALU front-end.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_MAX = 4'b1001;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // LED step indicator: the three entry steps, then one code for everything after.
  function automatic logic [1:0] stage_of(input state_t s);
    logic [1:0] st;
    st = 2'd3;
    case (s)
      S_A:     st = 2'd0;
      S_B:     st = 2'd1;
      S_OP:    st = 2'd2;
      default: st = 2'd3;
    endcase
    return st;
  endfunction

  // An opcode is refused if it is undefined, or if it divides by a zero operand B.
  function automatic logic op_rejected(input logic [3:0] op, input logic b_zero);
    logic rej;
    rej = 1'b0;
    if (op > OP_MAX) begin
      rej = 1'b1;
    end else begin
      case (op)
        OP_DIV, OP_MOD: rej = b_zero;
        OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR,
        OP_XOR, OP_SHL, OP_SHR: rej = 1'b0;
        default: rej = 1'b1;
      endcase
    end
    return rej;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for a raw button level followed by a registered
// rising-edge detector; a held button yields a single one-cycle pulse.
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  // sync[0]/sync[1] are the metastability pair, sync[2] is the previous synced level
  logic [2:0] sync;

  // Shift the level through the synchronizer and register the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 3'b000;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[1:0], din};
      pulse <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Operand/operator entry sequencer in front of the lab ALU. Captures A, B and
// the opcode on successive enter presses, screens illegal requests, and holds
// the ALU result and flags for the display.
//
// state  | meaning
// S_A    | waiting for operand A
// S_B    | waiting for operand B
// S_OP   | waiting for the operator; screens it on capture
// S_EXEC | ALU settling; result captured on the next edge
// S_DONE | result and flags held for display
// S_ERR  | request rejected; err shown until the next A capture
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enter,
  input  logic                  clear,
  input  logic [N_BITS-1:0]     data_in,
  input  logic [3:0]            op_in,
  output logic [N_BITS-1:0]     alu_a,
  output logic [N_BITS-1:0]     alu_b,
  output logic [3:0]            alu_op,
  input  logic [2*N_BITS-1:0]   alu_result,
  input  logic [3:0]            alu_flags,
  output logic [2*N_BITS-1:0]   result,
  output logic [3:0]            flags,
  output logic                  result_valid,
  output logic                  err,
  output logic [1:0]            stage
);

  logic                enter_p;
  state_t              state, state_d;
  logic [N_BITS-1:0]   a_d, b_d;
  logic [3:0]          op_d;
  logic [2*N_BITS-1:0] result_d;
  logic [3:0]          flags_d;
  logic                valid_d, err_d;
  logic [1:0]          stage_d;

  btn_edge_sync u_enter_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (enter),
    .pulse (enter_p)
  );

  // State and every output register; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_A;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= OP_ADD;
      result       <= '0;
      flags        <= 4'b0000;
      result_valid <= 1'b0;
      err          <= 1'b0;
      stage        <= 2'd0;
    end else begin
      state        <= state_d;
      alu_a        <= a_d;
      alu_b        <= b_d;
      alu_op       <= op_d;
      result       <= result_d;
      flags        <= flags_d;
      result_valid <= valid_d;
      err          <= err_d;
      stage        <= stage_d;
    end
  end

  // Next state and next register values; clear overrides any enter in the same cycle.
  always_comb begin
    state_d  = state;
    a_d      = alu_a;
    b_d      = alu_b;
    op_d     = alu_op;
    result_d = result;
    flags_d  = flags;
    valid_d  = result_valid;
    err_d    = err;

    if (clear) begin
      state_d  = S_A;
      a_d      = '0;
      b_d      = '0;
      op_d     = OP_ADD;
      result_d = '0;
      flags_d  = 4'b0000;
      valid_d  = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (state)
        S_A: begin
          if (enter_p) begin
            a_d     = data_in;
            valid_d = 1'b0;
            err_d   = 1'b0;
            state_d = S_B;
          end
        end
        S_B: begin
          if (enter_p) begin
            b_d     = data_in;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (enter_p) begin
            op_d = op_in;
            if (op_rejected(op_in, alu_b == '0)) begin
              // Flag the error on the capture edge itself and blank the display.
              state_d  = S_ERR;
              err_d    = 1'b1;
              result_d = '0;
              flags_d  = 4'b0000;
              valid_d  = 1'b0;
            end else begin
              state_d = S_EXEC;
            end
          end
        end
        S_EXEC: begin
          // Operands were registered one cycle ago, so the ALU output is settled now.
          result_d = alu_result;
          flags_d  = {alu_flags[FLAG_N], alu_flags[FLAG_Z],
                      alu_flags[FLAG_C], alu_flags[FLAG_V]};
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (enter_p) state_d = S_A;
        end
        S_ERR: begin
          if (enter_p) state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end

    stage_d = stage_of(state_d);
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU attached.
module tb_alu_op_sequencer;

  localparam int NB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enter;
  logic            clear;
  logic [NB-1:0]   data_in;
  logic [3:0]      op_in;
  logic [NB-1:0]   alu_a;
  logic [NB-1:0]   alu_b;
  logic [3:0]      alu_op;
  logic [2*NB-1:0] alu_result;
  logic [3:0]      alu_flags;
  logic [2*NB-1:0] result;
  logic [3:0]      flags;
  logic            result_valid;
  logic            err;
  logic [1:0]      stage;

  int n_checks = 0;
  int n_fail   = 0;

  // {alu_a, alu_b, alu_op, result, flags, result_valid, err, stage}
  logic [27:0] obs;
  assign obs = {alu_a, alu_b, alu_op, result, flags, result_valid, err, stage};

  alu_op_sequencer #(.N_BITS(NB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enter        (enter),
    .clear        (clear),
    .data_in      (data_in),
    .op_in        (op_in),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .result       (result),
    .flags        (flags),
    .result_valid (result_valid),
    .err          (err),
    .stage        (stage)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {result[7:0], N, Z, C, V}; N taken from operand-width MSB.
  function automatic logic [11:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] op);
    logic [7:0] r;
    logic c, v;
    r = 8'h00; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin r = 8'(a) + 8'(b); c = r[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      4'd1: begin r = {4'h0, 4'(a - b)}; c = (a < b); v = (a[3] != b[3]) && (r[3] != a[3]); end
      4'd2: r = 8'(a) * 8'(b);
      4'd3: r = (b == 4'd0) ? 8'h00 : 8'(a / b);
      4'd4: r = (b == 4'd0) ? 8'h00 : 8'(a % b);
      4'd5: r = {4'h0, a & b};
      4'd6: r = {4'h0, a | b};
      4'd7: r = {4'h0, a ^ b};
      4'd8: r = 8'(a) << b;
      4'd9: r = 8'(a) >> b;
      default: r = 8'h00;
    endcase
    return {r, r[3], (r == 8'h00), c, v};
  endfunction

  always_comb {alu_result, alu_flags} = ref_alu(alu_a, alu_b, alu_op);

  // One button press; returns at the negedge just after the FSM acted on it.
  task automatic press();
    enter = 1'b0;
    repeat (3) @(negedge clk);
    enter = 1'b1;
    repeat (4) @(negedge clk);
    enter = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic seq(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    data_in = a;
    press();
    data_in = b;
    press();
    op_in = op;
    press();
  endtask

  task automatic test_reset();
    logic [27:0] exp;
    rst_n = 1'b1; enter = 1'b0; clear = 1'b0; data_in = '0; op_in = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== 28'h0) begin
      n_fail++; $display("FAIL reset_init: got %h expected %h", obs, 28'h0);
    end
    rst_n = 1'b1;
    data_in = 4'd5; press();
    data_in = 4'd6; press();
    exp = {4'd5, 4'd6, 4'd0, 8'h00, 4'h0, 1'b0, 1'b0, 2'd2};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL reset_pre_op: got %h expected %h", obs, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 28'h0) begin
      n_fail++; $display("FAIL reset_async: got %h expected %h", obs, 28'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    data_in = 4'd11; press();
    exp = {4'd11, 4'd0, 4'd0, 8'h00, 4'h0, 1'b0, 1'b0, 2'd1};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL reset_first_a: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_add();
    logic [27:0] exp;
    do_clear();
    seq(4'd3, 4'd5, 4'b0000);
    exp = {4'd3, 4'd5, 4'd0, 8'h00, 4'h0, 1'b0, 1'b0, 2'd3};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL add_at_e: got %h expected %h", obs, exp);
    end
    @(negedge clk);
    exp = {4'd3, 4'd5, 4'd0, 8'h08, 4'b1001, 1'b1, 1'b0, 2'd3};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL add_at_e1: got %h expected %h", obs, exp);
    end
    press();
    exp = {4'd3, 4'd5, 4'd0, 8'h08, 4'b1001, 1'b1, 1'b0, 2'd0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL add_back_to_a: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_mul();
    logic [27:0] exp;
    seq(4'd7, 4'd6, 4'b0010);
    @(negedge clk);
    exp = {4'd7, 4'd6, 4'd2, 8'h2A, 4'b1000, 1'b1, 1'b0, 2'd3};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL mul_result: got %h expected %h", obs, exp);
    end
    data_in = 4'hF; op_in = 4'h0;
    repeat (50) @(negedge clk);
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL mul_hold: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_div0();
    logic [27:0] exp;
    press();
    seq(4'd9, 4'd0, 4'b0011);
    exp = {4'd9, 4'd0, 4'd3, 8'h00, 4'h0, 1'b0, 1'b1, 2'd3};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL div0_at_e: got %h expected %h", obs, exp);
    end
    press();
    exp = {4'd9, 4'd0, 4'd3, 8'h00, 4'h0, 1'b0, 1'b1, 2'd0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL div0_to_a: got %h expected %h", obs, exp);
    end
    data_in = 4'd4; press();
    exp = {4'd4, 4'd0, 4'd3, 8'h00, 4'h0, 1'b0, 1'b0, 2'd1};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL div0_err_clear: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_illegal();
    logic [27:0] exp;
    do_clear();
    seq(4'd1, 4'd1, 4'b0000);
    @(negedge clk);
    press();
    seq(4'd6, 4'd2, 4'b1100);
    exp = {4'd6, 4'd2, 4'hC, 8'h00, 4'h0, 1'b0, 1'b1, 2'd3};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL illegal_at_e: got %h expected %h", obs, exp);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL illegal_no_capture: got %h expected %h", obs, exp);
    end
    press();
    seq(4'd12, 4'd2, 4'b1001);
    exp = {4'd12, 4'd2, 4'h9, 8'h00, 4'h0, 1'b0, 1'b0, 2'd3};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL shr_at_e: got %h expected %h", obs, exp);
    end
    @(negedge clk);
    exp = {4'd12, 4'd2, 4'h9, 8'h03, 4'h0, 1'b1, 1'b0, 2'd3};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL shr_result: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_button();
    logic [27:0] exp;
    do_clear();
    data_in = 4'd5;
    enter = 1'b1;
    repeat (20) @(negedge clk);
    enter = 1'b0;
    repeat (4) @(negedge clk);
    exp = {4'd5, 4'd0, 4'd0, 8'h00, 4'h0, 1'b0, 1'b0, 2'd1};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL held_single_capture: got %h expected %h", obs, exp);
    end
    data_in = 4'd4; press();
    op_in = 4'b0000;
    repeat (3) @(negedge clk);
    enter = 1'b1;
    repeat (4) @(negedge clk);
    @(negedge clk);
    exp = {4'd5, 4'd4, 4'd0, 8'h09, 4'b1001, 1'b1, 1'b0, 2'd3};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL held_through_exec: got %h expected %h", obs, exp);
    end
    repeat (20) @(negedge clk);
    enter = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL held_stays_done: got %h expected %h", obs, exp);
    end
    press();
    data_in = 4'd7; press();
    do_clear();
    n_checks++;
    if (obs !== 28'h0) begin
      n_fail++; $display("FAIL clear_in_b: got %h expected %h", obs, 28'h0);
    end
    data_in = 4'd7; press();
    enter = 1'b0;
    repeat (3) @(negedge clk);
    enter = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    enter = 1'b0;
    n_checks++;
    if (obs !== 28'h0) begin
      n_fail++; $display("FAIL clear_beats_enter: got %h expected %h", obs, 28'h0);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (obs !== 28'h0) begin
      n_fail++; $display("FAIL clear_no_late_step: got %h expected %h", obs, 28'h0);
    end
  endtask

  task automatic test_random();
    logic [3:0]  a, b, op;
    logic [11:0] ref_val;
    logic [7:0]  m_res;
    logic [3:0]  m_fl;
    logic        m_valid, m_err, rej;
    logic [27:0] exp;
    do_clear();
    m_res = 8'h00; m_fl = 4'h0; m_valid = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 30; i++) begin
      a  = 4'($urandom_range(0, 15));
      b  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      op = 4'($urandom_range(0, 15));
      rej = (op > 4'd9) || ((op == 4'd3 || op == 4'd4) && b == 4'd0);
      seq(a, b, op);
      if (rej) begin
        m_res = 8'h00; m_fl = 4'h0; m_valid = 1'b0; m_err = 1'b1;
      end else begin
        m_valid = 1'b0; m_err = 1'b0;
      end
      exp = {a, b, op, m_res, m_fl, m_valid, m_err, 2'd3};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL rand_at_e[%0d]: got %h expected %h", i, obs, exp);
      end
      @(negedge clk);
      if (!rej) begin
        ref_val = ref_alu(a, b, op);
        m_res = ref_val[11:4]; m_fl = ref_val[3:0]; m_valid = 1'b1;
      end
      exp = {a, b, op, m_res, m_fl, m_valid, m_err, 2'd3};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL rand_at_e1[%0d]: got %h expected %h", i, obs, exp);
      end
      press();
      exp = {a, b, op, m_res, m_fl, m_valid, m_err, 2'd0};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL rand_back_to_a[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div0();
    test_illegal();
    test_button();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequential front-end controller for the lab ALU. It steps the user through entering operand A, operand B and the operator from shared board switches, using a single debounced "enter" button. It drives the registered operands and opcode into the combinational ALU, then captures and holds the result and N/Z/C/V flags for the display path. It also rejects division or modulo by zero and undefined opcodes before they reach the result registers.

## Interface
Parameters:
- N_BITS, 4, operand width; ALU result width is 2*N_BITS

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- enter  in  1  raw push-button level, asynchronous to clk
- clear  in  1  synchronous abort, active-high, already synchronous to clk
- data_in  in  N_BITS  operand switches
- op_in  in  4  operator switches
- alu_a  out  N_BITS  registered operand A to ALU
- alu_b  out  N_BITS  registered operand B to ALU
- alu_op  out  4  registered opcode to ALU
- alu_result  in  2*N_BITS  ALU combinational result
- alu_flags  in  4  ALU flags {N,Z,C,V}
- result  out  2*N_BITS  captured result
- flags  out  4  captured {N,Z,C,V}
- result_valid  out  1  result/flags hold a completed operation
- err  out  1  last operation was rejected
- stage  out  2  entry step for LEDs: 0=A, 1=B, 2=OP, 3=busy/done/error

## Operation
- enter passes through a 2-FF synchronizer, then a rising-edge detector, producing a 1-cycle enter_p.
  - A held button produces exactly one enter_p.
  - Raw edge to enter_p takes 3 clk edges.
- FSM states: S_A, S_B, S_OP, S_EXEC, S_DONE, S_ERR. Reset and clear state is S_A.
- S_A: on enter_p, alu_a<=data_in and clear result_valid/err; go to S_B.
- S_B: on enter_p, alu_b<=data_in; go to S_OP.
- S_OP: on enter_p, alu_op<=op_in.
  - Go to S_ERR if op_in>4'b1001, or if op_in is DIV (0011) or MOD (0100) with alu_b==0.
  - Otherwise go to S_EXEC.
- S_EXEC: the ALU settles for one cycle. Then result<=alu_result, flags<=alu_flags, result_valid<=1; go to S_DONE. enter_p is ignored.
- S_DONE: result and flags are held stable. On enter_p, go to S_A; result_valid stays 1 until the next A capture.
- S_ERR: err=1, result=0, flags=0, result_valid=0. On enter_p, go to S_A; err clears on the next A capture.
- clear has priority over enter_p in every state. It returns to S_A and loads every output register with its reset value. The synchronizer flops are not cleared.
- Reset values: alu_a=0, alu_b=0, alu_op=4'b0000, result=0, flags=0, result_valid=0, err=0, stage=0, state=S_A.
- rst_n asserted mid-operation forces reset values immediately, with no clock needed. The first enter_p after release is captured as A.

## Timing
- All outputs are registered; none depend combinationally on inputs.
- Edge E samples enter_p in S_OP. alu_op updates at E. result, flags and result_valid update at E+1.
- Error detection has no extra latency: err is high from E.
- stage follows state after the same edge.
- alu_a, alu_b and alu_op are stable in S_EXEC and S_DONE.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams ADD..SHR (0000..1001) and OP_MAX=4'b1001
  - the state enum typedef
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- One sub-module, btn_edge_sync: 2-FF synchronizer plus rising-edge pulse, with ports clk, rst_n, din, pulse.

## Test plan
- Reset: pulse rst_n low while in S_OP -> all outputs 0, stage=0 asynchronously; next enter captures A.
- ADD, N_BITS=4, real ALU: A=3, B=5, op=0000 -> result=8'h08, flags=4'b1001, result_valid at E+1, stage=3.
- MUL: A=7, B=6, op=0010 -> result=8'h2A, flags=4'b1000; result holds through 50 idle cycles.
- DIV by zero: A=9, B=0, op=0011 -> err=1 at E, result=0, result_valid=0. Next enter -> stage=0. Next enter -> err=0.
- Illegal opcode: op=4'b1100 -> err=1 and no result capture. Repeat with op=4'b1001 and B=2 -> valid SHR, err=0.
- Button/abort: enter held high 20 cycles -> one capture only. enter pulsed during S_EXEC -> ignored. clear in S_B -> stage=0, alu_a=0.
